// File: rtl/spike_enc_pkg.sv
// rtl/spike_enc_pkg.sv - shared types and constants for the spike rate encoder
package spike_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_S       = 5;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_T_STEPS = 16;

    // Fibonacci feedback taps 16,14,13,11 (bit n-1 for tap n)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < n) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spike_acc_channel.sv
// rtl/spike_acc_channel.sv - one rate-coding channel: pixel register and phase accumulator
module spike_acc_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [WIDTH-1:0] pixel_in,
    output logic             spike
);

    logic [WIDTH-1:0] pixel_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   acc_next;

    assign acc_next = {1'b0, acc} + {1'b0, pixel_q};
    assign spike    = acc_next[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= '0;
            acc     <= '0;
        end else if (clear) begin
            pixel_q <= pixel_in;
            acc     <= '0;
        end else if (step) begin
            acc <= acc_next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - pixel-to-spike-train encoder; SPIKE_LFSR_EN selects stochastic LFSR coding
module spike_rate_encoder
    import spike_enc_pkg::*;
#(
    parameter int          S         = DEF_S,
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          T_STEPS   = DEF_T_STEPS,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [S*WIDTH-1:0]        pixels_in,
    output logic [S-1:0]              spikes_out,
    output logic                      spike_valid,
    output logic [clog2(T_STEPS)-1:0] step_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = clog2(T_STEPS);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          clear;
    logic [S-1:0]  spike_vec;

    assign clear = (state == IDLE) && start;
    assign busy  = (state != IDLE);

`ifdef SPIKE_LFSR_EN
    logic [15:0]      lfsr;
    logic [WIDTH-1:0] pix_q [S];

    function automatic logic [WIDTH-1:0] rotl_low(input logic [15:0] v, input int r);
        logic [WIDTH-1:0] o;
        o = '0;
        for (int j = 0; j < WIDTH; j++) begin
            o[j] = v[(j - (r % 16) + 16) % 16];
        end
        return o;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
            for (int i = 0; i < S; i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            if (state == RUN) begin
                lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            end
            if (clear) begin
                for (int i = 0; i < S; i++) begin
                    pix_q[i] <= pixels_in[(S-i)*WIDTH-1 -: WIDTH];
                end
            end
        end
    end

    // Per-channel rotation keeps equal pixels from producing identical trains
    for (genvar i = 0; i < S; i++) begin : g_cmp
        assign spike_vec[S-1-i] = pix_q[i] > rotl_low(lfsr, i);
    end
`else
    logic step;

    assign step = (state == RUN) && !last;

    for (genvar i = 0; i < S; i++) begin : g_ch
        spike_acc_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .step     (step),
            .pixel_in (pixels_in[(S-i)*WIDTH-1 -: WIDTH]),
            .spike    (spike_vec[S-1-i])
        );
    end
`endif

    // last marks that step T_STEPS-1 is already on the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b0;
            spikes_out  <= '0;
            spike_valid <= 1'b0;
            step_idx    <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    spike_valid <= 1'b0;
                    spikes_out  <= '0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        last  <= 1'b0;
                    end
                end
                RUN: begin
                    if (last) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        spike_valid <= 1'b0;
                        spikes_out  <= '0;
                        last        <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        spikes_out  <= spike_vec;
                        spike_valid <= 1'b1;
                        step_idx    <= cnt;
                        if (cnt == CW'(T_STEPS - 1)) begin
                            last <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - scoreboard bench for the default (accumulator) build of spike_rate_encoder
module tb_spike_rate_encoder;

    localparam int S = 5;
    localparam int W = 8;
    localparam int T = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [S*W-1:0]   pixels_in;
    logic [S-1:0]     spikes_out;
    logic             spike_valid;
    logic [3:0]       step_idx;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    spike_rate_encoder #(.S(S), .WIDTH(W), .T_STEPS(T), .LFSR_SEED(16'hACE1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixels_in   (pixels_in),
        .spikes_out  (spikes_out),
        .spike_valid (spike_valid),
        .step_idx    (step_idx),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic [S-1:0] spk;
        int           step;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   valid_cnt = 0;
    int   last_done_cyc = 0;
    int   last_gap = -1;
    int   ch_cnt[S];
    int   d0;
    bit   seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: cumulative spikes after step k are floor((k+1)*p / 2^W)
    function automatic logic [S-1:0] model_spikes(input logic [S*W-1:0] pix, input int k);
        logic [S-1:0] r;
        int p;
        r = '0;
        for (int i = 0; i < S; i++) begin
            p = int'(pix[(S-i)*W-1 -: W]);
            if (((k + 1) * p) / (1 << W) != (k * p) / (1 << W)) begin
                r[S-1-i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic push_frame(input logic [S*W-1:0] pix);
        exp_t e;
        for (int k = 0; k < T; k++) begin
            e.spk  = model_spikes(pix, k);
            e.step = k;
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        for (int i = 0; i < S; i++) begin
            ch_cnt[i] = 0;
        end
    endtask

    task automatic run_frame(input logic [S*W-1:0] pix);
        bit accepted;
        accepted  = 1'b0;
        pixels_in = pix;
        start     = 1'b1;
        clear_counts();
        for (int n = 0; n < 8 && !accepted; n++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                accepted = 1'b1;
            end
        end
        start = 1'b0;
        check_eq("start_accepted", 32'(accepted), 32'd1);
        if (accepted) begin
            push_frame(pix);
        end
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end
        end
        #1;
        check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_counts(input string tag, input int e0, input int e1, input int e2,
                                input int e3, input int e4);
        int e [S];
        e = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < S; i++) begin
            check_eq($sformatf("%s_ch%0d_count", tag, i), 32'(ch_cnt[i]), 32'(e[i]));
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (spike_valid) begin
                valid_cnt++;
                if (step_idx == 4'd0) begin
                    last_gap = cyc - last_done_cyc;
                end
                for (int i = 0; i < S; i++) begin
                    ch_cnt[i] += int'(spikes_out[S-1-i]);
                end
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("spikes", 32'(spikes_out), 32'(mon_e.spk));
                    check_eq("step_idx", 32'(step_idx), 32'(mon_e.step));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [S*W-1:0] pix_a;
        logic [S*W-1:0] pix_b;
        logic [S*W-1:0] pix_c;
        pix_a = {5{8'd128}};
        pix_b = {8'd0, 8'd16, 8'd64, 8'd255, 8'd1};
        pix_c = {8'd200, 8'd37, 8'd128, 8'd99, 8'd255};

        rst       = 1'b1;
        start     = 1'b0;
        pixels_in = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_spikes", 32'(spikes_out), 32'd0);
        check_eq("rst_valid", 32'(spike_valid), 32'd0);
        check_eq("rst_step_idx", 32'(step_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Half-scale on every channel
        run_frame(pix_a);
        wait_done("f1");
        check_eq("f1_valid_cnt", 32'(valid_cnt), 32'd16);
        check_eq("f1_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("f1_queue_empty", 32'(exp_q.size()), 32'd0);
        check_counts("f1", 8, 8, 8, 8, 8);
        @(negedge clk);
        check_eq("f1_done_pulse_width", 32'(done), 32'd0);

        // Mixed intensities including 0 and full scale
        run_frame(pix_b);
        wait_done("f2");
        check_counts("f2", 0, 1, 4, 15, 0);
        check_eq("f2_done_cnt", 32'(done_cnt), 32'd2);

        // Input change and start pulse mid-frame are ignored
        run_frame(pix_a);
        repeat (5) @(negedge clk);
        pixels_in = pix_b;
        start     = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done("f3");
        check_counts("f3", 8, 8, 8, 8, 8);
        check_eq("f3_done_cnt", 32'(done_cnt), 32'd3);
        repeat (4) @(negedge clk);
        check_eq("f3_no_queued_frame", 32'(done_cnt), 32'd3);
        run_frame(pix_b);
        wait_done("f4");
        check_counts("f4", 0, 1, 4, 15, 0);

        // Asynchronous reset at step 7 aborts the frame
        @(negedge clk);
        run_frame(pix_b);
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            if (spike_valid && step_idx == 4'd7) begin
                seen = 1'b1;
            end
        end
        check_eq("abort_step7_seen", 32'(seen), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_spikes", 32'(spikes_out), 32'd0);
        check_eq("abort_valid", 32'(spike_valid), 32'd0);
        check_eq("abort_step_idx", 32'(step_idx), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
        run_frame(pix_b);
        wait_done("f5");
        check_counts("f5", 0, 1, 4, 15, 0);
        check_eq("f5_valid_cnt", 32'(valid_cnt), 32'd16);

        // Back-to-back frames with start held high
        @(negedge clk);
        d0        = done_cnt;
        pixels_in = pix_c;
        start     = 1'b1;
        seen      = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                seen = 1'b1;
            end
        end
        check_eq("b2b_start_accepted", 32'(seen), 32'd1);
        push_frame(pix_c);
        push_frame(pix_c);
        wait_done("b2b1");
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done("b2b2");
        check_eq("b2b_gap", 32'(last_gap), 32'd3);
        check_eq("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 2));
        repeat (4) @(negedge clk);
        check_eq("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("b2b_no_third", 32'(done_cnt), 32'(d0 + 2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
